// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_pkg: shared state encoding and address helpers for router_fsm     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package router_pkg;

  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    CHECK_PARITY_ERROR = 3'd4,
    FIFO_FULL_STATE    = 3'd5,
    LOAD_AFTER_FULL    = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  // Picks the per-port flag for an address; the invalid address selects nothing.
  function automatic logic port_sel(input logic [2:0] flags, input logic [ADDR_W-1:0] addr);
    case (addr)
      2'd0:    port_sel = flags[0];
      2'd1:    port_sel = flags[1];
      2'd2:    port_sel = flags[2];
      default: port_sel = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fsm: packet-level control FSM of the 3-port router                 |
// | Optional macro ROUTER_FSM_PKT_CNT_EN adds the completed-packet counter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module router_fsm
  import router_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
`ifdef ROUTER_FSM_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt
`endif
);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        w_empty;
  logic [2:0]        w_soft;
  logic              w_addr_ok;

  assign w_empty   = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_soft    = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign w_addr_ok = pkt_valid && (data_in != ADDR_INVALID);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == DECODE_ADDRESS) && w_addr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DECODE_ADDRESS:
        if (w_addr_ok)
          w_next_state = port_sel(w_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (port_sel(w_empty, r_addr))
          w_next_state = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        w_next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)
          w_next_state = FIFO_FULL_STATE;
        else if (!pkt_valid)
          w_next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full)
          w_next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)
          w_next_state = DECODE_ADDRESS;
        else if (low_pkt_valid)
          w_next_state = LOAD_PARITY;
        else
          w_next_state = LOAD_DATA;
      LOAD_PARITY:
        w_next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        w_next_state = DECODE_ADDRESS;
    endcase
    // A read timeout on the selected port abandons the packet from any state.
    if ((r_state != DECODE_ADDRESS) && port_sel(w_soft, r_addr))
      w_next_state = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    case (r_state)
      DECODE_ADDRESS:     detect_add = 1'b1;
      LOAD_FIRST_DATA:    lfd_state  = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      FIFO_FULL_STATE:    full_state    = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
      default:            ;
    endcase
    busy = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  end

`ifdef ROUTER_FSM_PKT_CNT_EN
  logic [CNT_W-1:0] r_pkt_cnt;

  always_ff @(posedge clock) begin
    if (!resetn)
      r_pkt_cnt <= '0;
    else if (r_state == LOAD_PARITY)
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
  end

  assign pkt_cnt = r_pkt_cnt;
`else
  localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire
